// File: rtl/dbus_arbiter.sv
// dbus_arbiter -- shares the CPU data bus between two masters.
//
// Master 0 is the RISC-V core and master 1 is the DMA / UART loader. The
// arbiter sits in front of the rbus/wbus decode and the read mux. The grant
// is combinational, so an access with no competitor costs no extra cycles.
// When both masters request in the same cycle, a round-robin pointer picks
// the winner. Master 1 can lock the bus, but only for bounded bursts while
// master 0 is waiting.
//
// Ports
//   clk, rstn            clock; asynchronous active-low reset
//   m0_rd/raddr          master 0 read request and address
//   m0_wr/waddr/wdata/wstrb  master 0 write request, address, data, strobes
//   m0_rdata             master 0 read data (fixed one-cycle latency)
//   m0_stall             master 0 must hold its request this cycle
//   m1_rd/raddr          master 1 read request and address
//   m1_wr/waddr/wdata/wstrb  master 1 write request, address, data, strobes
//   m1_lock              master 1 wants to keep ownership on following cycles
//   m1_gnt               master 1 request accepted this cycle
//   m1_rdata, m1_rvalid  master 1 read data and its valid flag
//   bus_rd/raddr         read channel toward the data bus
//   bus_wr/waddr/wdata/wstrb  write channel toward the data bus
//   bus_rdata            read mux data, valid one cycle after bus_rd
module dbus_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_rd,
  input  logic [31:0] m0_raddr,
  input  logic        m0_wr,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  input  logic        m1_rd,
  input  logic [31:0] m1_raddr,
  input  logic        m1_wr,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        bus_rd,
  output logic [31:0] bus_raddr,
  output logic        bus_wr,
  output logic [31:0] bus_waddr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOCKED  = 2'd1,
    S_RELEASE = 2'd2
  } lock_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } rd_owner_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  lock_state_t state;
  rd_owner_t   rd_owner;
  logic [7:0]  lock_cnt;
  logic        prio;

  logic req0, req1, gnt0, gnt1, contended;

  // ---- Stage 0: combinational grant and bus multiplexing ----
  assign req0      = m0_rd | m0_wr;
  assign req1      = m1_rd | m1_wr;
  assign contended = req0 & req1;

  // Master 1 wins if it is the only requester. Under contention it wins
  // while LOCKED. In RELEASE it never wins. Otherwise prio decides.
  assign gnt1 = req1 & (~req0 | (state == S_LOCKED) |
                        ((state != S_RELEASE) & prio));
  assign gnt0 = req0 & ~gnt1;

  assign m0_stall = req0 & ~gnt0;
  assign m1_gnt   = req1 & gnt1;

  always_comb begin
    bus_rd    = 1'b0;
    bus_raddr = '0;
    bus_wr    = 1'b0;
    bus_waddr = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    if (gnt0) begin
      bus_rd    = m0_rd;
      bus_raddr = m0_raddr;
      bus_wr    = m0_wr;
      bus_waddr = m0_waddr;
      bus_wdata = m0_wdata;
      bus_wstrb = m0_wstrb;
    end else if (gnt1) begin
      bus_rd    = m1_rd;
      bus_raddr = m1_raddr;
      bus_wr    = m1_wr;
      bus_waddr = m1_waddr;
      bus_wdata = m1_wdata;
      bus_wstrb = m1_wstrb;
    end
  end

  // ---- Stage 1: registered arbitration state and read ownership ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio     <= 1'b0;
      state    <= S_IDLE;
      lock_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      // The loser of a contended cycle is favoured next time.
      if (contended)
        prio <= gnt0;

      // Record which master owns the read whose data returns next cycle.
      if (gnt0 && m0_rd)
        rd_owner <= OWN_M0;
      else if (gnt1 && m1_rd)
        rd_owner <= OWN_M1;
      else
        rd_owner <= OWN_NONE;

      case (state)
        S_IDLE: begin
          if (gnt1 && m1_lock) begin
            state    <= S_LOCKED;
            lock_cnt <= '0;
          end
        end
        S_LOCKED: begin
          if (!m1_lock || !req1) begin
            state <= S_IDLE;
          end else if (req0) begin
            // Count only the cycles that master 0 spends waiting.
            if (lock_cnt == LOCK_LAST)
              state <= S_RELEASE;
            else
              lock_cnt <= lock_cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          if (m1_lock) begin
            state    <= S_LOCKED;
            lock_cnt <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- Stage 2: read data return, steered by the registered owner ----
  assign m0_rdata  = (rd_owner == OWN_M0) ? bus_rdata : 32'h0;
  assign m1_rdata  = (rd_owner == OWN_M1) ? bus_rdata : 32'h0;
  assign m1_rvalid = (rd_owner == OWN_M1);

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_rd, m0_wr, m1_rd, m1_wr, m1_lock;
  logic [31:0] m0_raddr, m0_waddr, m0_wdata, m1_raddr, m1_waddr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_rdata, m1_rdata, bus_raddr, bus_waddr, bus_wdata, bus_rdata;
  logic        m0_stall, m1_gnt, m1_rvalid, bus_rd, bus_wr;
  logic [3:0]  bus_wstrb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .m0_rd(m0_rd), .m0_raddr(m0_raddr), .m0_wr(m0_wr), .m0_waddr(m0_waddr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m0_stall(m0_stall),
    .m1_rd(m1_rd), .m1_raddr(m1_raddr), .m1_wr(m1_wr), .m1_waddr(m1_waddr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_rd(bus_rd), .bus_raddr(bus_raddr), .bus_wr(bus_wr),
    .bus_waddr(bus_waddr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0; m1_lock = 0;
    m0_raddr = 0; m0_waddr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_raddr = 0; m1_waddr = 0; m1_wdata = 0; m1_wstrb = 0;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle_all();
    bus_rdata = 32'hDEAD_BEEF;

    // Reset: registered outputs cleared, combinational path follows inputs
    m0_rd = 1; m0_raddr = 32'h0000_00A0;
    #1;
    chk("rst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_bus_rd_follows", {31'b0, bus_rd}, 32'd1);
    chk("rst_bus_raddr", bus_raddr, 32'h0000_00A0);
    idle_all();
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Only m0 reads
    m0_rd = 1; m0_raddr = 32'h0100_0010;
    #1;
    chk("t1_bus_rd", {31'b0, bus_rd}, 32'd1);
    chk("t1_bus_raddr", bus_raddr, 32'h0100_0010);
    chk("t1_m0_stall", {31'b0, m0_stall}, 32'd0);
    tick();
    idle_all(); bus_rdata = 32'h1111_2222;
    #1;
    chk("t1_m0_rdata", m0_rdata, 32'h1111_2222);
    chk("t1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("t1_m1_rdata", m1_rdata, 32'h0);
    chk("t1_idle_bus_rd", {31'b0, bus_rd}, 32'd0);
    tick();

    // Both write, prio=0: m0, then m1, then m0
    m0_wr = 1; m0_waddr = 32'h0000_1000; m0_wdata = 32'hAAAA_0000; m0_wstrb = 4'hF;
    m1_wr = 1; m1_waddr = 32'h0000_2000; m1_wdata = 32'hBBBB_0000; m1_wstrb = 4'h3;
    #1;
    chk("t2a_m0_stall", {31'b0, m0_stall}, 32'd0);
    chk("t2a_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("t2a_bus_waddr", bus_waddr, 32'h0000_1000);
    chk("t2a_bus_wdata", bus_wdata, 32'hAAAA_0000);
    tick();
    #1;
    chk("t2b_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    chk("t2b_m0_stall", {31'b0, m0_stall}, 32'd1);
    chk("t2b_bus_waddr", bus_waddr, 32'h0000_2000);
    chk("t2b_bus_wstrb", {28'b0, bus_wstrb}, 32'h3);
    tick();
    #1;
    chk("t2c_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("t2c_m0_stall", {31'b0, m0_stall}, 32'd0);
    tick();
    // prio is now 1
    idle_all();
    #1;
    chk("t2d_nogrant_wr", {31'b0, bus_wr}, 32'd0);
    chk("t2d_nogrant_waddr", bus_waddr, 32'h0);
    chk("t2d_nogrant_wdata", bus_wdata, 32'h0);
    tick();

    // m1 reads alone
    m1_rd = 1; m1_raddr = 32'h0200_0004;
    #1;
    chk("t3_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    chk("t3_bus_raddr", bus_raddr, 32'h0200_0004);
    tick();
    idle_all(); bus_rdata = 32'h3333_4444;
    #1;
    chk("t3_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    chk("t3_m1_rdata", m1_rdata, 32'h3333_4444);
    chk("t3_m0_rdata", m0_rdata, 32'h0);
    tick();

    // Lock burst with LOCK_MAX=4: lock taken while m0 idle, then m0 waits
    m1_rd = 1; m1_lock = 1; m1_raddr = 32'h0200_0100;
    #1;
    chk("t4_lock_take", {31'b0, m1_gnt}, 32'd1);
    tick();
    m0_rd = 1; m0_raddr = 32'h0100_0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_burst1_m1_gnt%0d", i), {31'b0, m1_gnt}, 32'd1);
      chk($sformatf("t4_burst1_m0_stall%0d", i), {31'b0, m0_stall}, 32'd1);
      tick();
    end
    #1;
    chk("t4_release1_m0_stall", {31'b0, m0_stall}, 32'd0);
    chk("t4_release1_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_burst2_m1_gnt%0d", i), {31'b0, m1_gnt}, 32'd1);
      tick();
    end
    // Second release; m1 drops its lock in the same cycle
    m1_lock = 0;
    #1;
    chk("t4_release2_m0_stall", {31'b0, m0_stall}, 32'd0);
    tick();
    // IDLE, prio=1 (m1 lost the release cycle)
    #1;
    chk("t4_after_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    tick();
    idle_all();
    tick();

    // Back-to-back reads m0, m1, m0
    m0_rd = 1; m0_raddr = 32'h0000_0004;
    tick();
    idle_all(); m1_rd = 1; m1_raddr = 32'h0000_0008; bus_rdata = 32'hC0DE_0001;
    #1;
    chk("t5_r1_m0_rdata", m0_rdata, 32'hC0DE_0001);
    chk("t5_r1_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    tick();
    idle_all(); m0_rd = 1; m0_raddr = 32'h0000_000C; bus_rdata = 32'hC0DE_0002;
    #1;
    chk("t5_r2_m1_rdata", m1_rdata, 32'hC0DE_0002);
    chk("t5_r2_m1_rvalid", {31'b0, m1_rvalid}, 32'd1);
    chk("t5_r2_m0_rdata", m0_rdata, 32'h0);
    tick();
    idle_all(); bus_rdata = 32'hC0DE_0003;
    #1;
    chk("t5_r3_m0_rdata", m0_rdata, 32'hC0DE_0003);
    chk("t5_r3_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("t5_r3_m1_rdata", m1_rdata, 32'h0);
    tick();

    // Reset during LOCKED with an m1 read in flight.
    // First force prio=1 through a contended cycle that m0 wins (prio=0 now).
    m0_wr = 1; m1_wr = 1;
    #1;
    chk("t6_setup_m0_wins", {31'b0, m0_stall}, 32'd0);
    tick();
    idle_all(); m1_rd = 1; m1_lock = 1;
    tick();
    // LOCKED, m1 reads alone (prio stays 1)
    tick();
    bus_rdata = 32'h5555_6666;
    #1;
    chk("t6_pre_rst_rvalid", {31'b0, m1_rvalid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t6_rst_rvalid", {31'b0, m1_rvalid}, 32'd0);
    chk("t6_rst_m1_rdata", m1_rdata, 32'h0);
    rstn = 1'b1;
    m0_rd = 1; m0_raddr = 32'h0100_0200;
    #1;
    chk("t6_post_m0_stall", {31'b0, m0_stall}, 32'd0);
    chk("t6_post_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("t6_post_bus_raddr", bus_raddr, 32'h0100_0200);
    tick();
    idle_all();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single CPU data bus (dmem_rd/raddr/rdata, dmem_wr/waddr/wdata/wstrb) between two masters: master 0 (RISC-V core) and master 1 (DMA / UART loader).
- Sits between the masters and the existing rbus/wbus decode plus read mux.
- Grant is combinational, so an uncontended access costs zero cycles.
- Contention is resolved round-robin; master 1 may lock the bus for bounded bursts. Losing master 0 is held with stall.

Parameters:
- LOCK_MAX, 16, maximum consecutive granted cycles for a locked master-1 burst while master 0 is waiting (range 1..255).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-low
- m0_rd  in  1  master 0 read request
- m0_raddr  in  32  master 0 read address
- m0_wr  in  1  master 0 write request
- m0_waddr  in  32  master 0 write address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes
- m0_rdata  out  32  master 0 read data
- m0_stall  out  1  master 0 must hold its request (connects to riscv stall)
- m1_rd  in  1  master 1 read request
- m1_raddr  in  32  master 1 read address
- m1_wr  in  1  master 1 write request
- m1_waddr  in  32  master 1 write address
- m1_wdata  in  32  master 1 write data
- m1_wstrb  in  4  master 1 byte strobes
- m1_lock  in  1  master 1 requests to keep ownership on following cycles
- m1_gnt  out  1  master 1 request accepted this cycle
- m1_rdata  out  32  master 1 read data
- m1_rvalid  out  1  m1_rdata valid (one cycle after a granted read)
- bus_rd  out  1  to the data bus
- bus_raddr  out  32  to the data bus
- bus_wr  out  1  to the data bus
- bus_waddr  out  32  to the data bus
- bus_wdata  out  32  to the data bus
- bus_wstrb  out  4  to the data bus
- bus_rdata  in  32  from the read mux; valid one cycle after bus_rd

Behaviour:
- Request definition: reqN = mN_rd | mN_wr. A granted master drives all bus_* fields. Both rd and wr may be granted in the same cycle.
- Grant is combinational within the cycle:
  - Only one master requesting: that master wins.
  - Both requesting: the winner is selected by the registered pointer `prio` (0 = m0 favoured, 1 = m1 favoured), unless the lock state forces m1.
- `prio` update (registered): after any contended cycle, prio becomes the loser. Uncontended cycles leave prio unchanged.
- Lock state machine:
  - States: IDLE, LOCKED, RELEASE.
  - IDLE -> LOCKED when m1 is granted with m1_lock=1.
  - LOCKED: m1 wins regardless of prio. lock_cnt increments only on cycles where m0 requests.
  - LOCKED -> IDLE when m1_lock=0 or m1 stops requesting.
  - LOCKED -> RELEASE when lock_cnt reaches LOCK_MAX-1 while m0 requests.
  - RELEASE: m0 wins if requesting, for exactly one cycle. Then go to LOCKED if m1_lock is still 1 (lock_cnt cleared), else IDLE.
  - lock_cnt is cleared on every entry to LOCKED.
- No grant: bus_rd=bus_wr=0; address, data and strobe are forced to 0.
- Outputs:
  - m0_stall = req0 & ~gnt0.
  - m1_gnt = req1 & gnt1.
- Read return:
  - Registered rd_owner (NONE, M0, M1) is captured from the granted read.
  - Next cycle: bus_rdata goes to the owner's rdata; the other master's rdata is 0.
  - m1_rvalid=1 when rd_owner=M1.
  - m0 uses the fixed 1-cycle latency, so it has no rvalid.
- Pipelining: a new read may be granted in the same cycle a previous read's data returns. Owners are tracked per cycle, with no bubbles.
- Reset values (async, rstn low):
  - prio=0, state=IDLE, lock_cnt=0, rd_owner=NONE.
  - m1_rvalid=0, m0_rdata=m1_rdata=0.
  - Combinational outputs follow the inputs.
- Reset asserted mid-burst abandons the lock. A read in flight has its data discarded: rd_owner=NONE.
- A stalled master must hold its request stable; the arbiter does not buffer requests.

Test Plan:
- Only m0 reads 0x0100_0010 -> bus_rd=1 with the same address in the same cycle; m0_stall=0; next cycle m0_rdata=bus_rdata, m1_rvalid=0.
- Both write, prio=0 -> m0 granted, m0_stall=0, m1_gnt=0. Next cycle both still requesting -> m1 granted, m0_stall=1. Grants alternate.
- m1 reads 0x0200_0004 while m0 is idle -> m1_gnt=1; next cycle m1_rvalid=1, m1_rdata=bus_rdata, m0_rdata=0.
- m1_lock=1 with m0 requesting continuously, LOCK_MAX=4 -> m1 granted for 4 cycles, m0 granted for 1 (RELEASE), then m1 for 4 more.
- Back-to-back reads m0, m1, m0 on consecutive cycles -> rdata routed to m0, m1, m0 one cycle later each, with correct rvalid.
- rstn pulsed low during LOCKED with an m1 read in flight -> m1_rvalid=0 immediately; after release, contention favours m0 (prio=0).
